// File: rtl/uart_tx_port_if.sv
// CPU MEM-stage data bus (rd/wr/addr/wdata/rdata) as seen by memory-mapped peripherals.
interface uart_tx_port_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and polled status.
// Optional TX-drained interrupt enabled by defining UART_TX_IRQ_EN.
module uart_tx_port #(
    parameter int          BAUD_DIV   = 2083,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] TXD_ADDR   = 32'h4000_0018,
    parameter logic [31:0] CON_ADDR   = 32'h4000_0020
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_port_if.slave  bus,
    output logic           UART_TX,
    output logic           irqout
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [BW-1:0] baud_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg, ovf_reg, irq_en_reg, irq_reg;

    logic txd_sel, con_sel, full, empty, busy, push_req, push, pop;
    logic unused_wdata;

    assign txd_sel  = (bus.addr == TXD_ADDR);
    assign con_sel  = (bus.addr == CON_ADDR);
    assign full     = (count_reg == DEPTH_C);
    assign empty    = (count_reg == '0);
    assign busy     = (state_reg != IDLE) || !empty;
    assign push_req = bus.wr && txd_sel;
    assign push     = push_req && !full;
    assign pop      = (state_reg == IDLE) && !empty;

    assign UART_TX      = tx_reg;
    assign irqout       = irq_reg;
    assign unused_wdata = ^bus.wdata;

    // Status layout: bit4 irq_en, bit3 ovf, bit2 empty, bit1 full, bit0 busy.
    always_comb begin
        bus.rdata = '0;
        if (bus.rd && con_sel)
            bus.rdata = {27'b0, irq_en_reg, ovf_reg, empty, full, busy};
    end

    // FIFO storage kept out of the reset path so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            baud_reg   <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            ovf_reg    <= 1'b0;
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase

            // A write into a full FIFO is lost even if a pop frees a slot on this edge.
            if (push_req && full)
                ovf_reg <= 1'b1;
            else if (bus.wr && con_sel && bus.wdata[3])
                ovf_reg <= 1'b0;

`ifdef UART_TX_IRQ_EN
            if (bus.wr && con_sel)
                irq_en_reg <= bus.wdata[4];
            irq_reg <= irq_en_reg && empty && (state_reg == IDLE);
`else
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
`endif

            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        baud_reg  <= '0;
                        tx_reg    <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        idx_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg <= '0;
                        if (idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                            tx_reg  <= shift_reg[idx_reg + 3'd1];
                        end
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: frame-level reference model compared every cycle,
// plus directed checks with hand-computed values and a serial-line decoder.
module tb_uart_tx_port;
    localparam int          B     = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TXD   = 32'h4000_0018;
    localparam logic [31:0] CON   = 32'h4000_0020;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic UART_TX, irqout;
    uart_tx_port_if bus_if();

    uart_tx_port #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH), .TXD_ADDR(TXD), .CON_ADDR(CON)) dut (
        .clk(clk), .reset(reset), .bus(bus_if), .UART_TX(UART_TX), .irqout(irqout));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a queue of line levels, one per cycle, for the frame in flight.
    logic [7:0] fifo_m[$];
    logic       line_m[$];
    logic       tx_m = 1'b1, ovf_m = 1'b0, irq_en_m = 1'b0, irq_m = 1'b0;

    function automatic logic [31:0] con_m();
        logic busy_m;
        busy_m = (line_m.size() > 0) || (fifo_m.size() > 0);
        return {27'b0, irq_en_m, ovf_m, fifo_m.size() == 0, fifo_m.size() == DEPTH, busy_m};
    endfunction

    always @(posedge clk) begin
        bit idle_b, empty_b, full_b;
        logic [7:0] b;
        if (!reset) begin
            fifo_m.delete(); line_m.delete();
            tx_m = 1'b1; ovf_m = 1'b0; irq_en_m = 1'b0; irq_m = 1'b0;
        end else begin
            idle_b  = (line_m.size() == 0);
            empty_b = (fifo_m.size() == 0);
            full_b  = (fifo_m.size() == DEPTH);
`ifdef UART_TX_IRQ_EN
            irq_m = irq_en_m && empty_b && idle_b;
`else
            irq_m = 1'b0;
`endif
            if (idle_b && !empty_b) begin
                b = fifo_m.pop_front();
                repeat (B) line_m.push_back(1'b0);
                for (int k = 0; k < 8; k++) repeat (B) line_m.push_back(b[k]);
                repeat (B) line_m.push_back(1'b1);
                line_m.push_back(1'b1);  // the single idle cycle before the next start
            end
            if (bus_if.wr && bus_if.addr == TXD) begin
                if (full_b) ovf_m = 1'b1;
                else fifo_m.push_back(bus_if.wdata[7:0]);
            end
            if (bus_if.wr && bus_if.addr == CON) begin
                if (bus_if.wdata[3]) ovf_m = 1'b0;
`ifdef UART_TX_IRQ_EN
                irq_en_m = bus_if.wdata[4];
`endif
            end
            tx_m = (line_m.size() > 0) ? line_m.pop_front() : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_tx", {31'b0, UART_TX}, {31'b0, tx_m});
            check("irqout", {31'b0, irqout}, {31'b0, irq_m});
            if (bus_if.rd)
                check("rdata", bus_if.rdata, (bus_if.addr == CON) ? con_m() : 32'h0);
        end
    end

    // Serial decoder sampling mid-bit.
    logic [7:0] rx_q[$];
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte;
    always @(negedge clk) begin
        if (!reset) begin
            rx_busy = 1'b0;
        end else begin
            if (!rx_busy && UART_TX === 1'b0) begin
                rx_busy = 1'b1;
                rx_t = 0;
            end
            if (rx_busy) begin
                rx_t++;
                for (int k = 0; k < 8; k++)
                    if (rx_t == B + B/2 + k*B) rx_byte[k] = UART_TX;
                if (rx_t == 9*B + B/2) begin
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        tick();
        bus_if.wr = 1'b0;
        $display("write addr=%h data=%h t=%0t", a, d, $time);
    endtask

    task automatic bus_read(input logic [31:0] a, input string name, input logic [31:0] exp);
        bus_if.rd = 1'b1; bus_if.addr = a;
        #1;
        check(name, bus_if.rdata, exp);
        $display("read  addr=%h data=%h t=%0t", a, bus_if.rdata, $time);
        bus_if.rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200us", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp55;
        int lows;
        exp55 = 10'b1010101010;  // symbol i = bit i: start 0, data 1,0,1,0,1,0,1,0, stop 1
        bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        check("reset_tx", {31'b0, UART_TX}, 32'h1);
        check("reset_irq", {31'b0, irqout}, 32'h0);
        bus_read(CON, "reset_con", 32'h4);

        // Single frame 0x55, literal waveform
        rx_q.delete();
        bus_write(TXD, 32'h55);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("frame55_bit", {31'b0, UART_TX}, {31'b0, exp55[(k-1)/B]});
            if (k == 40) bus_read(CON, "frame55_busy", 32'h5);
        end
        tick();
        check("frame55_idle", {31'b0, UART_TX}, 32'h1);
        bus_read(CON, "frame55_con", 32'h4);
        check("frame55_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) check("frame55_rx", {24'b0, rx_q[0]}, 32'h55);

        // Overflow: ten consecutive pushes into an eight-entry FIFO
        rx_q.delete();
        for (int i = 1; i <= 10; i++) begin
            bus_if.wr = 1'b1; bus_if.addr = TXD; bus_if.wdata = i;
            tick();
        end
        bus_if.wr = 1'b0;
        bus_read(CON, "ovf_con", 32'hB);
        bus_write(CON, 32'h8);
        bus_read(CON, "ovf_clear", 32'h3);
        repeat (9*(10*B+1) + 10) tick();
        bus_read(CON, "drain_con", 32'h4);
        check("drain_rx_n", rx_q.size(), 9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            check("drain_rx", {24'b0, rx_q[i]}, i + 1);

        // Reset in the middle of DATA bit 3 with three bytes queued
        bus_write(TXD, 32'hA1);
        bus_write(TXD, 32'hA2);
        bus_write(TXD, 32'hA3);
        bus_write(TXD, 32'hA4);
        repeat (15) tick();
        reset = 1'b0;
        tick();
        check("midreset_tx", {31'b0, UART_TX}, 32'h1);
        reset = 1'b1;
        bus_read(CON, "midreset_con", 32'h4);
        lows = 0;
        repeat (60) begin
            tick();
            if (UART_TX !== 1'b1) lows++;
        end
        check("midreset_quiet", lows, 0);

        // Unmapped address: write ignored, read returns 0
        bus_if.rd = 1'b1;
        bus_write(32'h4000_001C, 32'h77);
        check("unmapped_rd", bus_if.rdata, 32'h0);
        bus_if.rd = 1'b0;
        lows = 0;
        repeat (20) begin
            tick();
            if (UART_TX !== 1'b1) lows++;
        end
        check("unmapped_quiet", lows, 0);
        bus_read(CON, "unmapped_con", 32'h4);

        // CON bit 4: interrupt enable when built in, otherwise reads back 0
`ifdef UART_TX_IRQ_EN
        bus_write(CON, 32'h10);
        tick();
        check("irq_on", {31'b0, irqout}, 32'h1);
        bus_write(TXD, 32'hA5);
        check("irq_hold", {31'b0, irqout}, 32'h1);
        tick();
        check("irq_push", {31'b0, irqout}, 32'h0);
        repeat (10*B + 2) tick();
        check("irq_drain", {31'b0, irqout}, 32'h1);
        bus_write(CON, 32'h0);
        tick();
        check("irq_off", {31'b0, irqout}, 32'h0);
`else
        bus_write(CON, 32'h10);
        tick();
        bus_read(CON, "irq_bit_con", 32'h4);
        check("irq_tied", {31'b0, irqout}, 32'h0);
`endif
        repeat (5) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
